// File: rtl/riscmakers_icache_nway.sv
// N-way set-associative instruction cache: tag lookup, first-invalid/round-robin victim,
// set-walking flush, single outstanding refill. Optional perf counters: RISCMAKERS_ICACHE_PERF_EN.
module riscmakers_icache_nway #(
  parameter int unsigned     NUM_WAYS       = 2,
  parameter int unsigned     NUM_SETS       = 64,
  parameter int unsigned     LINE_WIDTH     = 128,
  parameter int unsigned     FETCH_WIDTH    = 32,
  parameter int unsigned     PLEN           = 34,
  parameter int unsigned     CACHE_ID_WIDTH = 4,
  parameter int unsigned     RD_TX_ID       = 0,
  parameter logic [PLEN-1:0] CACHE_BASE     = 34'h8000_0000,
  parameter logic [PLEN-1:0] CACHE_SIZE     = 34'h4000_0000,
  localparam int unsigned    WAY_W          = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic                      flush_i,
  output logic                      flush_ack_o,
  input  logic                      req_i,
  input  logic                      spec_i,
  input  logic                      kill_s1_i,
  input  logic                      kill_s2_i,
  input  logic [PLEN-1:0]           vaddr_i,
  output logic                      ready_o,
  output logic                      valid_o,
  output logic [FETCH_WIDTH-1:0]    data_o,
  output logic [PLEN-1:0]           vaddr_o,
  output logic                      miss_o,
  output logic                      mem_data_req_o,
  input  logic                      mem_data_ack_i,
  output logic [PLEN-1:0]           mem_paddr_o,
  output logic                      mem_nc_o,
  output logic [WAY_W-1:0]          mem_way_o,
  output logic [CACHE_ID_WIDTH-1:0] mem_tid_o,
  input  logic                      mem_rtrn_vld_i,
  input  logic                      mem_rtrn_ifill_i,
  input  logic [LINE_WIDTH-1:0]     mem_rtrn_data_i
`ifdef RISCMAKERS_ICACHE_PERF_EN
  ,
  output logic [31:0]               hit_cnt_o,
  output logic [31:0]               miss_cnt_o
`endif
);

  localparam int unsigned OFF_W  = $clog2(LINE_WIDTH / 8);
  localparam int unsigned IDX_W  = $clog2(NUM_SETS);
  localparam int unsigned TAG_W  = PLEN - IDX_W - OFF_W;
  localparam int unsigned FB_W   = $clog2(FETCH_WIDTH / 8);
  localparam int unsigned WORD_W = $clog2(LINE_WIDTH / FETCH_WIDTH);
  localparam logic [PLEN:0] CACHE_END = {1'b0, CACHE_BASE} + {1'b0, CACHE_SIZE};

  typedef enum logic [2:0] {
    FLUSH, IDLE, TAG_COMPARE, WAIT_SPEC, MEM_ACK, MEM_DATA, KILL_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [WAY_W-1:0]  rr_q, rr_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic [PLEN-1:0]   addr_q, addr_d;
  logic              nc_q, nc_d;
  logic              kill_q, kill_d;
  logic              flush_pend_q, flush_pend_d;
  logic              mem_req_q, mem_req_d;
  logic              flush_ack_q, flush_ack_d;

  logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
  logic [TAG_W-1:0]      tag_q   [NUM_WAYS][NUM_SETS];
  logic [LINE_WIDTH-1:0] data_q  [NUM_WAYS][NUM_SETS];

  logic [IDX_W-1:0]      idx_c;
  logic [TAG_W-1:0]      tag_c;
  logic [WORD_W-1:0]     wsel_c;
  logic [NUM_WAYS-1:0]   hit_vec_c;
  logic [LINE_WIDTH-1:0] hit_line_c;
  logic [LINE_WIDTH-1:0] line_c;
  logic [WAY_W-1:0]      vict_c;
  logic                  inv_found_c;
  logic                  all_valid_c;
  logic                  nc_c;
  logic                  rtrn_c;
  logic                  fill_we_c;
  state_e                done_st_c;

  assign idx_c  = addr_q[OFF_W +: IDX_W];
  assign tag_c  = addr_q[PLEN-1 -: TAG_W];
  assign wsel_c = addr_q[OFF_W-1:FB_W];
  assign rtrn_c = mem_rtrn_vld_i & mem_rtrn_ifill_i;
  assign nc_c   = !en_i || ({1'b0, vaddr_i} < {1'b0, CACHE_BASE}) || ({1'b0, vaddr_i} >= CACHE_END);

  // Parallel tag compare and victim choice for the latched set
  always_comb begin
    hit_vec_c   = '0;
    hit_line_c  = '0;
    vict_c      = rr_q;
    inv_found_c = 1'b0;
    all_valid_c = &valid_q[idx_c];
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[idx_c][w] && (tag_q[w][idx_c] == tag_c)) begin
        hit_vec_c[w] = 1'b1;
        hit_line_c   = hit_line_c | data_q[w][idx_c];
      end
      if (!inv_found_c && !valid_q[idx_c][w]) begin
        vict_c      = WAY_W'(w);
        inv_found_c = 1'b1;
      end
    end
  end

  assign line_c = (state_q == TAG_COMPARE) ? hit_line_c : mem_rtrn_data_i;

  // Next-state and response logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_d         = rr_q;
    victim_d     = victim_q;
    addr_d       = addr_q;
    nc_d         = nc_q;
    kill_d       = kill_q;
    flush_pend_d = flush_pend_q | (flush_i && (state_q != IDLE) && (state_q != FLUSH));
    flush_ack_d  = 1'b0;
    valid_o      = 1'b0;
    miss_o       = 1'b0;
    fill_we_c    = 1'b0;
    data_o       = '0;
    done_st_c    = flush_pend_d ? FLUSH : IDLE;

    unique case (state_q)
      FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(NUM_SETS - 1)) begin
          flush_ack_d = 1'b1;
          state_d     = IDLE;
        end
      end
      IDLE: begin
        if (flush_i) begin
          state_d = FLUSH;
        end else if (req_i && !kill_s1_i) begin
          addr_d  = vaddr_i;
          nc_d    = nc_c;
          kill_d  = 1'b0;
          state_d = nc_c ? WAIT_SPEC : TAG_COMPARE;
        end
      end
      TAG_COMPARE: begin
        if (kill_s2_i) begin
          state_d = done_st_c;
        end else if (|hit_vec_c) begin
          valid_o = 1'b1;
          state_d = done_st_c;
        end else begin
          miss_o   = 1'b1;
          victim_d = vict_c;
          if (all_valid_c) begin
            rr_d = (rr_q == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_q + 1'b1;
          end
          state_d = WAIT_SPEC;
        end
      end
      WAIT_SPEC: begin
        if (kill_s2_i) begin
          state_d = done_st_c;
        end else if (!spec_i) begin
          state_d = MEM_ACK;
        end
      end
      MEM_ACK: begin
        // a kill here must still let the handshake finish; remember it
        if (kill_s2_i) begin
          kill_d = 1'b1;
        end
        if (mem_data_ack_i) begin
          state_d = (kill_s2_i || kill_q) ? KILL_DRAIN : MEM_DATA;
        end
      end
      MEM_DATA: begin
        if (rtrn_c) begin
          fill_we_c = !nc_q;
          valid_o   = !kill_s2_i;
          state_d   = done_st_c;
        end else if (kill_s2_i) begin
          state_d = KILL_DRAIN;
        end
      end
      KILL_DRAIN: begin
        if (rtrn_c) begin
          fill_we_c = !nc_q;
          state_d   = done_st_c;
        end
      end
      default: state_d = FLUSH;
    endcase

    if ((state_d == FLUSH) && (state_q != FLUSH)) begin
      cnt_d        = '0;
      flush_pend_d = 1'b0;
    end
    mem_req_d = (state_d == MEM_ACK);
    if (valid_o) begin
      data_o = FETCH_WIDTH'(line_c >> (FETCH_WIDTH * 32'(wsel_c)));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= FLUSH;
      cnt_q        <= '0;
      rr_q         <= '0;
      victim_q     <= '0;
      addr_q       <= '0;
      nc_q         <= 1'b0;
      kill_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      mem_req_q    <= 1'b0;
      flush_ack_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_q         <= rr_d;
      victim_q     <= victim_d;
      addr_q       <= addr_d;
      nc_q         <= nc_d;
      kill_q       <= kill_d;
      flush_pend_q <= flush_pend_d;
      mem_req_q    <= mem_req_d;
      flush_ack_q  <= flush_ack_d;
    end
  end

  // Storage arrays: valid bits are cleared by the flush walk, not by reset
  always_ff @(posedge clk_i) begin
    if (state_q == FLUSH) begin
      valid_q[cnt_q] <= '0;
    end
    if (fill_we_c) begin
      valid_q[idx_c][victim_q] <= 1'b1;
      tag_q[victim_q][idx_c]   <= tag_c;
      data_q[victim_q][idx_c]  <= mem_rtrn_data_i;
    end
  end

  assign ready_o        = (state_q == IDLE);
  assign flush_ack_o    = flush_ack_q;
  assign vaddr_o        = addr_q;
  assign mem_data_req_o = mem_req_q;
  assign mem_nc_o       = nc_q;
  assign mem_way_o      = victim_q;
  assign mem_tid_o      = CACHE_ID_WIDTH'(RD_TX_ID);
  assign mem_paddr_o    = nc_q ? {addr_q[PLEN-1:3], 3'b000}
                               : {addr_q[PLEN-1:OFF_W], {OFF_W{1'b0}}};

  assert property (@(posedge clk_i) disable iff (rst_i)
                   (state_q == TAG_COMPARE) |-> $onehot0(hit_vec_c));

`ifdef RISCMAKERS_ICACHE_PERF_EN
  logic        hit_c;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  assign hit_c = valid_o && (state_q == TAG_COMPARE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (flush_ack_d) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_c && !(&hit_cnt_q)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (miss_o && !(&miss_cnt_q)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
